// File: rtl/game_flow.sv
// Round sequencer for the kitchen game: pre-round countdown, play/pause, round end,
// final and session-high score latching. Clocked by vsync, one edge per frame.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for the first start press after reset
// S_COUNTDOWN | on-screen 3-2-1; round timer reloaded on entry
// S_PLAYING   | round timer running; watching time_left for expiry
// S_PAUSED    | round timer frozen until the next pause press
// S_GAME_OVER | score latched; start ignored until the hold-off has elapsed
module game_flow #(
   parameter int ONE_SEC       = 60,
   parameter int COUNTDOWN_SEC = 3,
   parameter int OVER_HOLD     = 120
) (
   input  logic       vsync,
   input  logic       restart_n,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic [7:0] time_left,
   input  logic [9:0] score_in,
   output logic [2:0] game_state,
   output logic       timer_go,
   output logic       restart,
   output logic [3:0] count_left,
   output logic [9:0] final_score,
   output logic [9:0] high_score,
   output logic       new_high
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_PLAYING   = 3'd2,
      S_PAUSED    = 3'd3,
      S_GAME_OVER = 3'd4
   } state_t;

   // frame_cnt serves both the countdown second divider and the game-over hold-off
   localparam int CNT_MAX = ((ONE_SEC - 1) > OVER_HOLD) ? (ONE_SEC - 1) : OVER_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] WRAP_VAL = CNT_W'(ONE_SEC - 1);
   localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(OVER_HOLD);
   localparam logic [3:0]       CD_INIT  = 4'(COUNTDOWN_SEC);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [3:0]       count_left_q, count_left_d;
   logic [9:0]       final_score_q, final_score_d;
   logic [9:0]       high_score_q, high_score_d;
   logic             new_high_q, new_high_d;
   logic             timer_go_q, timer_go_d;
   logic             restart_q, restart_d;
   logic             start_q, pause_q;
   logic             start_rise, pause_rise;

   assign start_rise = start_btn & ~start_q;
   assign pause_rise = pause_btn & ~pause_q;

   always_comb begin
      state_d       = state_q;
      frame_cnt_d   = frame_cnt_q;
      count_left_d  = count_left_q;
      final_score_d = final_score_q;
      high_score_d  = high_score_q;
      new_high_d    = new_high_q;

      case (state_q)
         S_IDLE: begin
            if (start_rise) state_d = S_COUNTDOWN;
         end
         S_COUNTDOWN: begin
            if (frame_cnt_q == WRAP_VAL) begin
               frame_cnt_d = '0;
               if (count_left_q == 4'd1) begin
                  state_d      = S_PLAYING;
                  count_left_d = 4'd0;
               end else begin
                  count_left_d = count_left_q - 4'd1;
               end
            end else begin
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end
         S_PLAYING: begin
            if (time_left == 8'd0) state_d = S_GAME_OVER;
            else if (pause_rise)   state_d = S_PAUSED;
         end
         S_PAUSED: begin
            if (pause_rise) state_d = S_PLAYING;
         end
         S_GAME_OVER: begin
            if (frame_cnt_q == HOLD_VAL) begin
               if (start_rise) state_d = S_COUNTDOWN;
            end else begin
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_COUNTDOWN && state_q != S_COUNTDOWN) begin
         count_left_d = CD_INIT;
         frame_cnt_d  = '0;
         new_high_d   = 1'b0;
      end

      if (state_d == S_GAME_OVER && state_q != S_GAME_OVER) begin
         final_score_d = score_in;
         frame_cnt_d   = '0;
         if (score_in > high_score_q) begin
            high_score_d = score_in;
            new_high_d   = 1'b1;
         end else begin
            new_high_d   = 1'b0;
         end
      end

      restart_d  = (state_d == S_COUNTDOWN) && (state_q != S_COUNTDOWN);
      timer_go_d = (state_d == S_PLAYING);
   end

   // Button history resets high so a press held through reset is not an edge
   always_ff @(posedge vsync or negedge restart_n) begin
      if (!restart_n) begin
         state_q       <= S_IDLE;
         frame_cnt_q   <= '0;
         count_left_q  <= 4'd0;
         final_score_q <= 10'd0;
         high_score_q  <= 10'd0;
         new_high_q    <= 1'b0;
         timer_go_q    <= 1'b0;
         restart_q     <= 1'b0;
         start_q       <= 1'b1;
         pause_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         frame_cnt_q   <= frame_cnt_d;
         count_left_q  <= count_left_d;
         final_score_q <= final_score_d;
         high_score_q  <= high_score_d;
         new_high_q    <= new_high_d;
         timer_go_q    <= timer_go_d;
         restart_q     <= restart_d;
         start_q       <= start_btn;
         pause_q       <= pause_btn;
      end
   end

   assign game_state  = state_q;
   assign timer_go    = timer_go_q;
   assign restart     = restart_q;
   assign count_left  = count_left_q;
   assign final_score = final_score_q;
   assign high_score  = high_score_q;
   assign new_high    = new_high_q;

endmodule
